// File: rtl/arp_cache_ctrl.sv
// arp_cache_ctrl: ARP cache with ageing and a miss-driven request/retry resolution engine
module arp_cache_ctrl #(
  parameter int P_ENTRIES      = 8,
  parameter int P_TICK_CYCLES  = 156250,
  parameter int P_AGE_MAX      = 60000,
  parameter int P_RETRY_CYCLES = 156250,
  parameter int P_MAX_RETRY    = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_flush,
  input  logic [31:0]                      i_learn_ip,
  input  logic [47:0]                      i_learn_mac,
  input  logic                             i_learn_valid,
  input  logic [31:0]                      i_seek_ip,
  input  logic                             i_seek_valid,
  output logic                             o_seek_ready,
  output logic                             o_seek_done,
  output logic                             o_seek_hit,
  output logic [47:0]                      o_seek_mac,
  output logic [31:0]                      o_req_ip,
  output logic                             o_req_valid,
  input  logic                             i_req_ready,
  output logic [$clog2(P_ENTRIES+1)-1:0]   o_entry_count
);
  localparam int IW = $clog2(P_ENTRIES);
  localparam int AW = $clog2(P_AGE_MAX + 1);
  localparam int TW = $clog2(P_TICK_CYCLES + 1);
  localparam int WW = $clog2(P_RETRY_CYCLES + 1);
  localparam int RW = $clog2(P_MAX_RETRY + 1);
  localparam int CW = $clog2(P_ENTRIES + 1);
  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [P_ENTRIES-1:0] valid_q, valid_d;
  logic [31:0] ip_q [P_ENTRIES];
  logic [31:0] ip_d [P_ENTRIES];
  logic [47:0] mac_q [P_ENTRIES];
  logic [47:0] mac_d [P_ENTRIES];
  logic [AW-1:0] age_q [P_ENTRIES];
  logic [AW-1:0] age_d [P_ENTRIES];
  logic [TW-1:0] tick_q, tick_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] sip_q, sip_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [WW-1:0] timer_q, timer_d;
  logic hit_q, hit_d;
  logic [47:0] res_q, res_d;
  logic tick, learn_ok, m_any, f_any, lk_hit;
  logic [IW-1:0] m_idx, f_idx, o_idx, w_idx;
  logic [47:0] lk_mac;
  always_comb begin
    tick = tick_q == TW'(P_TICK_CYCLES - 1);
    tick_d = tick ? '0 : tick_q + 1'b1;
    learn_ok = i_learn_valid && i_learn_ip != '0;
    m_any = 1'b0;
    m_idx = '0;
    f_any = 1'b0;
    f_idx = '0;
    lk_hit = 1'b0;
    lk_mac = '0;
    count_d = '0;
    for (int i = P_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && ip_q[i] == i_learn_ip) begin m_any = 1'b1; m_idx = IW'(i); end
      if (!valid_q[i]) begin f_any = 1'b1; f_idx = IW'(i); end
      if (valid_q[i] && ip_q[i] == sip_q) begin lk_hit = 1'b1; lk_mac = mac_q[i]; end
      count_d = count_d + CW'(valid_q[i]);
    end
    count_d = i_flush ? '0 : count_d;
    // strict compare keeps the lowest index among equally old entries
    o_idx = '0;
    for (int i = 1; i < P_ENTRIES; i++)
      if (age_q[i] > age_q[o_idx]) o_idx = IW'(i);
    w_idx = m_any ? m_idx : f_any ? f_idx : o_idx;
    valid_d = valid_q;
    ip_d = ip_q;
    mac_d = mac_q;
    age_d = age_q;
    for (int i = 0; i < P_ENTRIES; i++)
      if (tick && valid_q[i]) begin
        age_d[i] = age_q[i] + 1'b1;
        valid_d[i] = age_d[i] != AW'(P_AGE_MAX);
      end
    if (learn_ok) begin
      valid_d[w_idx] = 1'b1;
      ip_d[w_idx] = i_learn_ip;
      mac_d[w_idx] = i_learn_mac;
      age_d[w_idx] = '0;
    end
    valid_d = i_flush ? '0 : valid_d;
  end
  always_comb begin
    state_d = state_q;
    sip_d = sip_q;
    retry_d = retry_q;
    timer_d = timer_q;
    hit_d = hit_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (i_seek_valid) begin sip_d = i_seek_ip; retry_d = '0; state_d = LOOKUP; end
      LOOKUP:
        if (lk_hit && !i_flush) begin state_d = DONE; hit_d = 1'b1; res_d = lk_mac; end
        else state_d = REQ;
      REQ: if (i_req_ready) begin retry_d = retry_q + 1'b1; timer_d = WW'(P_RETRY_CYCLES); state_d = WAIT; end
      WAIT: begin
        timer_d = timer_q - 1'b1;
        if (i_learn_valid && i_learn_ip == sip_q) begin state_d = DONE; hit_d = 1'b1; res_d = i_learn_mac; end
        else if (timer_q == WW'(1)) begin
          if (retry_q < RW'(P_MAX_RETRY)) state_d = REQ;
          else begin state_d = DONE; hit_d = 1'b0; res_d = '0; end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      ip_q <= '{default: '0};
      mac_q <= '{default: '0};
      age_q <= '{default: '0};
      tick_q <= '0;
      count_q <= '0;
      sip_q <= '0;
      retry_q <= '0;
      timer_q <= '0;
      hit_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ip_q <= ip_d;
      mac_q <= mac_d;
      age_q <= age_d;
      tick_q <= tick_d;
      count_q <= count_d;
      sip_q <= sip_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      hit_q <= hit_d;
      res_q <= res_d;
    end
  end
  // handshake outputs drop combinationally while reset is held
  assign o_seek_ready = i_rst && state_q == IDLE;
  assign o_seek_done = i_rst && state_q == DONE;
  assign o_req_valid = i_rst && state_q == REQ;
  assign o_req_ip = sip_q;
  assign o_seek_hit = hit_q;
  assign o_seek_mac = res_q;
  assign o_entry_count = count_q;
endmodule

// File: tb/tb_arp_cache_ctrl.sv
// tb_arp_cache_ctrl: randomized scoreboard bench for arp_cache_ctrl against a table-level reference model
module tb_arp_cache_ctrl;
  localparam int E = 4;
  localparam int TICK = 50;
  localparam int AGE = 6;
  localparam int RET = 20;
  localparam int MAXR = 3;
  localparam int CW = $clog2(E + 1);
  typedef struct {int cyc; logic hit; logic [47:0] mac;} done_t;
  typedef struct {int cyc; logic [31:0] ip;} req_t;
  logic clk = 0;
  logic i_rst = 0, i_flush = 0, i_learn_valid = 0, i_seek_valid = 0, i_req_ready = 1;
  logic [31:0] i_learn_ip = '0, i_seek_ip = '0;
  logic [47:0] i_learn_mac = '0;
  logic o_seek_ready, o_seek_done, o_seek_hit, o_req_valid;
  logic [47:0] o_seek_mac;
  logic [31:0] o_req_ip;
  logic [CW-1:0] o_entry_count;
  int n_vec = 0, n_err = 0, cyc = 0;
  done_t exp_q[$];
  req_t req_q[$];
  done_t de;
  req_t re;
  bit mv[E];
  logic [31:0] mip[E];
  logic [47:0] mmac[E];
  int mage[E];
  int mtick = 0, mcnt = 0;

  arp_cache_ctrl #(.P_ENTRIES(E), .P_TICK_CYCLES(TICK), .P_AGE_MAX(AGE),
                   .P_RETRY_CYCLES(RET), .P_MAX_RETRY(MAXR)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_learn_ip(i_learn_ip), .i_learn_mac(i_learn_mac), .i_learn_valid(i_learn_valid),
    .i_seek_ip(i_seek_ip), .i_seek_valid(i_seek_valid), .o_seek_ready(o_seek_ready),
    .o_seek_done(o_seek_done), .o_seek_hit(o_seek_hit), .o_seek_mac(o_seek_mac),
    .o_req_ip(o_req_ip), .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_entry_count(o_entry_count));

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // reference table: applies one clock edge of learn/flush/ageing rules
  task automatic model_update();
    int n, tgt;
    bit tk;
    if (!i_rst) begin
      for (int i = 0; i < E; i++) begin mv[i] = 0; mage[i] = 0; end
      mtick = 0;
      mcnt = 0;
    end else begin
      n = 0;
      for (int i = 0; i < E; i++) n += int'(mv[i]);
      tgt = -1;
      for (int i = 0; i < E; i++) if (tgt < 0 && mv[i] && mip[i] == i_learn_ip) tgt = i;
      for (int i = 0; i < E; i++) if (tgt < 0 && !mv[i]) tgt = i;
      if (tgt < 0) begin
        tgt = 0;
        for (int i = 1; i < E; i++) if (mage[i] > mage[tgt]) tgt = i;
      end
      tk = mtick == TICK - 1;
      mtick = tk ? 0 : mtick + 1;
      if (tk) for (int i = 0; i < E; i++) if (mv[i]) begin
        mage[i]++;
        if (mage[i] >= AGE) mv[i] = 0;
      end
      if (i_learn_valid && i_learn_ip != 0) begin
        mv[tgt] = 1; mip[tgt] = i_learn_ip; mmac[tgt] = i_learn_mac; mage[tgt] = 0;
      end
      if (i_flush) for (int i = 0; i < E; i++) mv[i] = 0;
      mcnt = i_flush ? 0 : n;
    end
  endtask

  function automatic bit mlook(input logic [31:0] ip, output logic [47:0] mac);
    mac = '0;
    for (int i = 0; i < E; i++) if (mv[i] && mip[i] == ip) begin mac = mmac[i]; return 1; end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    chk("entry_count", 64'(o_entry_count), 64'(mcnt));
  endtask

  function automatic logic [31:0] pool(input int k);
    return 32'hC0A86400 | 32'(k);
  endfunction

  function automatic logic [47:0] rmac();
    return {16'($urandom()), $urandom()};
  endfunction

  task automatic learn1(input logic [31:0] ip, input logic [47:0] mac);
    i_learn_ip = ip; i_learn_mac = mac; i_learn_valid = 1;
    step();
    i_learn_valid = 0;
  endtask

  // rk=0: no reply; rk=k: reply d cycles after the k-th request
  task automatic seek(input logic [31:0] ip, input int rk, input int d, input logic [47:0] mac);
    int t, done, w, k, g;
    bit h;
    logic [47:0] m;
    logic [31:0] oip;
    done_t e;
    req_t r;
    g = 0;
    while (o_seek_ready !== 1'b1 && g < 200) begin step(); g++; end
    if (g == 200) begin n_vec++; n_err++; $display("FAIL seek_ready_timeout cyc=%0d", cyc); end
    i_seek_ip = ip; i_seek_valid = 1; t = cyc;
    step();
    i_seek_valid = 0;
    h = mlook(ip, m);
    w = -1;
    if (h) begin
      done = t + 2; e.cyc = done; e.hit = 1; e.mac = m;
    end else begin
      k = rk == 0 ? MAXR : rk;
      for (int j = 0; j < k; j++) begin r.cyc = t + 2 + j * (RET + 1); r.ip = ip; req_q.push_back(r); end
      if (rk == 0) begin
        done = t + 2 + MAXR * (RET + 1); e.hit = 0; e.mac = '0;
      end else begin
        w = t + 2 + (k - 1) * (RET + 1) + d; done = w + 1; e.hit = 1; e.mac = mac;
      end
      e.cyc = done;
    end
    exp_q.push_back(e);
    while (cyc <= done) begin
      if (cyc == w) begin
        i_learn_ip = ip; i_learn_mac = mac; i_learn_valid = 1;
      end else if ($urandom_range(0, 7) == 0) begin
        do oip = pool($urandom_range(1, 6)); while (oip == ip);
        i_learn_ip = oip; i_learn_mac = rmac(); i_learn_valid = 1;
      end
      step();
      i_learn_valid = 0;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (o_seek_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++; $display("FAIL unexpected_done cyc=%0d hit=%0b", cyc, o_seek_hit);
      end else begin
        de = exp_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(de.cyc));
        chk("seek_hit", 64'(o_seek_hit), 64'(de.hit));
        chk("seek_mac", 64'(o_seek_mac), 64'(de.mac));
      end
    end
    if (o_req_valid === 1'b1 && i_req_ready) begin
      if (req_q.size() == 0) begin
        n_vec++; n_err++; $display("FAIL unexpected_req cyc=%0d ip=%0h", cyc, o_req_ip);
      end else begin
        re = req_q.pop_front();
        chk("req_cycle", 64'(cyc), 64'(re.cyc));
        chk("req_ip", 64'(o_req_ip), 64'(re.ip));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    repeat (3) step();
    chk("rst_ready", 64'(o_seek_ready), 0);
    chk("rst_req_valid", 64'(o_req_valid), 0);
    chk("rst_done", 64'(o_seek_done), 0);
    i_rst = 1;
    step();
    chk("rel_ready", 64'(o_seek_ready), 1);
    chk("rel_hit", 64'(o_seek_hit), 0);
    chk("rel_mac", 64'(o_seek_mac), 0);
    chk("rel_req_valid", 64'(o_req_valid), 0);
    learn1(32'hC0A86464, 48'h001122334455);
    seek(32'hC0A86464, 0, 0, '0);
    learn1(pool(1), rmac());
    learn1(pool(2), rmac());
    step();
    chk("count3", 64'(o_entry_count), 3);
    i_flush = 1;
    step();
    i_flush = 0;
    chk("flush_count", 64'(o_entry_count), 0);
    seek(32'hC0A86432, 0, 0, '0);
    seek(32'hC0A86432, 2, 5, 48'hAABBCCDDEE01);
    seek(32'hC0A86433, 1, RET, 48'h0A0B0C0D0E0F);
    repeat (AGE * TICK + 10) step();
    chk("aged_out", 64'(o_entry_count), 0);
    i_seek_ip = 32'hC0A86499; i_seek_valid = 1;
    step();
    i_seek_valid = 0;
    step();
    chk("req_before_rst", 64'(o_req_valid), 1);
    i_rst = 0;
    #1;
    chk("rst_drops_req", 64'(o_req_valid), 0);
    step();
    i_rst = 1;
    step();
    chk("rst_ready_after", 64'(o_seek_ready), 1);
    chk("rst_req_after", 64'(o_req_valid), 0);
    repeat (120) begin
      op = $urandom_range(0, 9);
      if (op < 4) learn1($urandom_range(0, 15) == 0 ? 32'h0 : pool($urandom_range(1, 6)), rmac());
      else if (op < 8) seek(pool($urandom_range(1, 6)), $urandom_range(0, 3), $urandom_range(1, RET), rmac());
      else if (op == 8) repeat ($urandom_range(1, 80)) step();
      else begin
        i_flush = 1;
        step();
        i_flush = 0;
      end
    end
    repeat (5) step();
    chk("done_queue_empty", 64'(exp_q.size()), 0);
    chk("req_queue_empty", 64'(req_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/arp_cache_ctrl.md
# arp_cache_ctrl

Parametrised ARP cache and resolution engine, the next generation of the ARP table plus request path. Holds `P_ENTRIES` IP→MAC bindings learned from the ARP receive path and ages them out. Serves MAC lookups from the IP transmit path. On a miss it drives ARP request generation itself, with bounded retries and timeout, then returns the resolved MAC or a failure. It sits between ARP RX (learn port), ARP TX (request port) and the IP layer (seek port).

## Interface
Parameters:
- `P_ENTRIES`, 8: number of cache entries; 2..64.
- `P_TICK_CYCLES`, 156250: clock cycles per ageing tick (1 ms at 156.25 MHz).
- `P_AGE_MAX`, 60000: ticks without refresh before an entry is invalidated.
- `P_RETRY_CYCLES`, 156250: cycles to wait for a reply after each request.
- `P_MAX_RETRY`, 3: requests issued per seek before failure; ≥1.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset. Synchronous, active-low.
- `i_flush` in 1: single-cycle pulse; invalidate all entries.
- `i_learn_ip` in 32: sender IP from ARP RX.
- `i_learn_mac` in 48: sender MAC from ARP RX.
- `i_learn_valid` in 1: single-cycle learn strobe.
- `i_seek_ip` in 32: IP to resolve.
- `i_seek_valid` in 1: seek request; held until accepted.
- `o_seek_ready` out 1: high only in IDLE.
- `o_seek_done` out 1: single-cycle completion pulse.
- `o_seek_hit` out 1: valid with done; 1 means resolved, 0 means failed.
- `o_seek_mac` out 48: resolved MAC, valid with done when hit=1; 0 on failure.
- `o_req_ip` out 32: target IP for ARP request.
- `o_req_valid` out 1: request to ARP TX; held until ready.
- `i_req_ready` in 1: ARP TX accepts request.
- `o_entry_count` out clog2(P_ENTRIES+1): number of valid entries.

## Operation
- Each entry holds valid, ip[31:0], mac[47:0] and age[clog2(P_AGE_MAX+1)-1:0].
- Learn priority:
  - If the IP matches a valid entry, overwrite its MAC and set age=0.
  - Otherwise write the lowest-index invalid entry with age=0.
  - If the table is full, replace the entry with the largest age; ties go to the lowest index.
- Learns with IP 0.0.0.0 are ignored.
- Ageing:
  - A free-running counter wraps at `P_TICK_CYCLES`-1. On wrap, every valid entry's age increments.
  - An entry whose age reaches `P_AGE_MAX` is invalidated in the same cycle.
  - If a learn and an ageing tick hit the same entry in the same cycle, the learn wins: age=0.
- Seek FSM states: IDLE, LOOKUP, REQ, WAIT, DONE.
  - IDLE: when seek_valid & ready, latch the IP, clear the retry counter, go to LOOKUP.
  - LOOKUP: parallel compare against all valid entries. Hit goes to DONE with hit=1. Miss goes to REQ.
  - REQ: o_req_valid=1, o_req_ip=latched IP. On req_ready, increment retries, load the wait timer with `P_RETRY_CYCLES`, go to WAIT.
  - WAIT: if i_learn_valid arrives with the latched IP, go to DONE with hit=1 and MAC=i_learn_mac; the learn also writes the table. If the timer expires and retries < `P_MAX_RETRY`, go to REQ. If it expires and retries = `P_MAX_RETRY`, go to DONE with hit=0.
  - DONE: pulse o_seek_done for one cycle, go to IDLE.
- Flush clears all entries and o_entry_count next cycle. An in-flight seek is not aborted. A flush during LOOKUP forces a miss.
- Reset:
  - Clears the table, counters and FSM (IDLE).
  - All outputs are 0, except o_seek_ready, which is 1 from the first cycle after reset release.
  - A reset mid-request drops o_req_valid immediately without a handshake.

## Timing
- Seek accepted in cycle T: LOOKUP in T+1; on a hit, o_seek_done/hit/mac are asserted in T+2. Miss: o_req_valid from T+2.
- A learn in cycle T is visible to a LOOKUP in T+1 or later. A LOOKUP in cycle T does not see a learn in cycle T, except through the WAIT-state bypass.
- WAIT match: a learn in cycle W gives o_seek_done in W+1.
- Timeout: req accepted in cycle R gives the next o_req_valid in R+`P_RETRY_CYCLES`+1.
- o_req_ip is stable while o_req_valid is high. o_seek_mac/o_seek_hit hold their values until the next done.
- o_entry_count is registered and lags the table by one cycle.

## Test plan
- Learn 192.168.100.100→00:11:22:33:44:55, then seek the same IP → done at T+2, hit=1, mac=00:11:22:33:44:55; entry_count=1.
- Seek 192.168.100.50 on an empty table, hold req_ready=1, no reply → 3 requests spaced `P_RETRY_CYCLES`+1 apart, then done hit=0, mac=0.
- Seek miss; after the 2nd request, learn 192.168.100.50→AA:BB:CC:DD:EE:01 → done the next cycle, hit=1, mac=AA:BB:CC:DD:EE:01; no 3rd request.
- `P_ENTRIES`=4: learn 5 distinct IPs with a tick between each → the first-learned (oldest) entry is replaced; entry_count=4; seek of the first IP misses.
- `P_AGE_MAX`=2, `P_TICK_CYCLES`=10: learn one entry → invalid after the 2nd tick (cycle 20), entry_count 1→0. A re-learn coinciding with the tick keeps the entry with age=0.
- Flush while entry_count=3 and reset asserted mid-REQ → count=0 next cycle; req_valid=0 and seek_ready=1 after reset.
